uart_mem_cmd_ctrl: RTL and testbench

- Parametrised command engine between a uart_basic byte interface and a simple dual-use memory port. Successor to the single-width UART/BRAM controller.
- Parses ASCII "@w" write sessions and "@r" read sessions, with configurable data width, depth and memory read latency.
- Correctly pipelines memory reads and replies with "D"/"E" plus LF status.
- Instantiated in top between uart_basic and blk_mem_gen.

---
 rtl/uart_mem_cmd_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_mem_cmd_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_mem_cmd_ctrl
// ASCII command engine between a byte UART (uart_basic) and a single memory
// port (blk_mem_gen). "@w\n" opens a write session of decimal words, one per
// LF, closed by '$'. "@r\n" reads back every word of the last write session,
// MSB byte first. Every session ends with "D\n" (done) or "E\n" (error).
//
// Parameters:
//   DATA_W          memory word width, multiple of 8 in 8..32
//   ADDR_W          memory address width
//   DEPTH           usable words, 1..2**ADDR_W
//   RD_LAT          memory read latency in cycles, 1..3
//   TIMEOUT_CYCLES  inter-byte timeout (only with CMD_TIMEOUT_EN)
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   rx_data, rx_ready      received byte and its one-cycle strobe
//   tx_data, tx_start      byte to send and its one-cycle request
//   tx_busy                transmitter busy (from the cycle after tx_start)
//   mem_en, mem_we         memory enable / write enable
//   mem_addr, mem_wdata    memory address / write data
//   mem_rdata              read data, valid RD_LAT cycles after a read
//   word_count             words written in the last write session
//   busy                   high whenever the engine is not idle
//   done_pulse, err_pulse  one-cycle pulse with the "D" / "E" tx_start
//
// Build option:
//   CMD_TIMEOUT_EN  when defined, a session that stalls for TIMEOUT_CYCLES
//                   between bytes (before reading starts) ends with "E\n".
// -----------------------------------------------------------------------------
module uart_mem_cmd_ctrl #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done_pulse,
    output logic              err_pulse
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned ACC_W = DATA_W + 4;
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_W      = 8'h77;
    localparam logic [7:0] CH_R      = 8'h72;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_D      = 8'h44;
    localparam logic [7:0] CH_E      = 8'h45;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;

    // Reject configurations the datapath is not sized for.
    if (DATA_W < 8 || DATA_W > 32 || (DATA_W % 8) != 0 ||
        RD_LAT < 1 || RD_LAT > 3 || DEPTH < 1 || ADDR_W > 30 ||
        DEPTH > (32'd1 << ADDR_W) || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_mem_cmd_ctrl: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_WR_HDR,
        S_RD_HDR,
        S_WR_DATA,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_SEND,
        S_ST_CHAR,
        S_ST_LF,
        S_ST_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               seen_q, seen_d;
    logic [CNT_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]   wc_q, wc_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         lat_q, lat_d;
    logic               is_err_q, is_err_d;

    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic               digit_c;
    logic [ACC_W-1:0]   acc_ext_c;
    logic               overflow_c;
    logic               full_c;
    logic               tx_ok_c;
    logic [7:0]         tx_byte_c;
    logic               timeout_c;

    // A new byte may only be started once the previous start has turned
    // into tx_busy and that busy has dropped again.
    assign tx_ok_c    = !tx_busy && !tx_start_q;
    assign digit_c    = (rx_data >= CH_0) && (rx_data <= CH_9);
    assign acc_ext_c  = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(rx_data - CH_0);
    assign overflow_c = |acc_ext_c[ACC_W-1:DATA_W];
    assign full_c     = (addr_q == CNT_W'(DEPTH));

    // Byte of the latched read word selected by idx_q, MSB byte first.
    always_comb begin
        tx_byte_c = word_q[DATA_W-1 -: 8];
        for (int b = 0; b < BYTES; b++) begin
            if (idx_q == 2'(b)) begin
                tx_byte_c = word_q[DATA_W-1-8*b -: 8];
            end
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Inter-byte timer: cleared by every received byte, runs only while a
    // session is waiting for input.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_c = 1'b0;
        if (rx_ready) begin
            to_cnt_d = '0;
        end else if (state_q inside {S_CMD, S_WR_HDR, S_RD_HDR, S_WR_DATA}) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        seen_d      = seen_q;
        addr_d      = addr_q;
        wc_d        = wc_q;
        word_d      = word_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        is_err_d    = is_err_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_ready && rx_data == CH_AT) begin
                    state_d = S_CMD;
                end
            end

            S_CMD: begin
                if (rx_ready) begin
                    if (rx_data == CH_W) begin
                        state_d = S_WR_HDR;
                    end else if (rx_data == CH_R) begin
                        state_d = S_RD_HDR;
                    end else begin
                        state_d  = S_ST_CHAR;
                        is_err_d = 1'b1;
                    end
                end
            end

            S_WR_HDR: begin
                if (rx_ready) begin
                    if (rx_data == CH_LF) begin
                        state_d = S_WR_DATA;
                        addr_d  = '0;
                        wc_d    = '0;
                        acc_d   = '0;
                        seen_d  = 1'b0;
                    end else begin
                        state_d  = S_ST_CHAR;
                        is_err_d = 1'b1;
                    end
                end
            end

            S_RD_HDR: begin
                if (rx_ready) begin
                    if (rx_data == CH_LF) begin
                        state_d = S_RD_ISSUE;
                        addr_d  = '0;
                    end else begin
                        state_d  = S_ST_CHAR;
                        is_err_d = 1'b1;
                    end
                end
            end

            S_WR_DATA: begin
                if (rx_ready) begin
                    if (digit_c) begin
                        if (overflow_c) begin
                            state_d  = S_ST_CHAR;
                            is_err_d = 1'b1;
                        end else begin
                            acc_d  = acc_ext_c[DATA_W-1:0];
                            seen_d = 1'b1;
                        end
                    end else if (rx_data == CH_LF || rx_data == CH_DOLLAR) begin
                        // '$' flushes a pending value exactly like LF, then ends.
                        if (seen_q && full_c) begin
                            state_d  = S_ST_CHAR;
                            is_err_d = 1'b1;
                        end else begin
                            if (seen_q) begin
                                mem_en_d    = 1'b1;
                                mem_we_d    = 1'b1;
                                mem_addr_d  = addr_q[ADDR_W-1:0];
                                mem_wdata_d = acc_q;
                                addr_d      = addr_q + CNT_W'(1);
                                wc_d        = wc_q + CNT_W'(1);
                                acc_d       = '0;
                                seen_d      = 1'b0;
                            end
                            if (rx_data == CH_DOLLAR) begin
                                state_d  = S_ST_CHAR;
                                is_err_d = 1'b0;
                            end
                        end
                    end else begin
                        state_d  = S_ST_CHAR;
                        is_err_d = 1'b1;
                    end
                end
            end

            S_RD_ISSUE: begin
                // Covers both an empty session and the end of the word list.
                if (addr_q == wc_q) begin
                    state_d  = S_ST_CHAR;
                    is_err_d = 1'b0;
                end else begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = addr_q[ADDR_W-1:0];
                    lat_d      = '0;
                    state_d    = S_RD_WAIT;
                end
            end

            S_RD_WAIT: begin
                // lat_q counts cycles since mem_en was on the port.
                if (lat_q == 2'(RD_LAT)) begin
                    word_d  = mem_rdata;
                    idx_d   = '0;
                    state_d = S_RD_SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

            S_RD_SEND: begin
                if (tx_ok_c) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = tx_byte_c;
                    if (idx_q == 2'(BYTES - 1)) begin
                        addr_d  = addr_q + CNT_W'(1);
                        state_d = S_RD_ISSUE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            S_ST_CHAR: begin
                if (tx_ok_c) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = is_err_q ? CH_E : CH_D;
                    done_d     = !is_err_q;
                    err_d      = is_err_q;
                    state_d    = S_ST_LF;
                end
            end

            S_ST_LF: begin
                if (tx_ok_c) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = CH_LF;
                    state_d    = S_ST_DRAIN;
                end
            end

            S_ST_DRAIN: begin
                if (tx_ok_c) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled session aborts; timeout_c is never set with a byte present.
        if (timeout_c) begin
            state_d  = S_ST_CHAR;
            is_err_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            seen_q      <= 1'b0;
            addr_q      <= '0;
            wc_q        <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            lat_q       <= '0;
            is_err_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            seen_q      <= seen_d;
            addr_q      <= addr_d;
            wc_q        <= wc_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            is_err_q    <= is_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = wc_q;
    assign busy       = busy_q;
    assign done_pulse = done_q;
    assign err_pulse  = err_q;

endmodule

// File: tb/tb_uart_mem_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_mem_cmd_ctrl
// Drives ASCII sessions into uart_mem_cmd_ctrl (16-bit words, 6-word depth,
// read latency 2) with a randomly slow UART and a latency-accurate memory,
// and compares tx bytes, memory writes, word_count and status pulses with a
// session-level reference parser.
// -----------------------------------------------------------------------------
module tb_uart_mem_cmd_ctrl;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 3;
    localparam int unsigned DEP = 6;
    localparam int unsigned RDL = 2;
    localparam int unsigned BY  = DW / 8;
    localparam longint      MAXV = (longint'(1) << DW) - 1;

    typedef logic [7:0] u8_t;

    logic          clk = 1'b0;
    logic          rst;
    u8_t           rx_data;
    logic          rx_ready;
    u8_t           tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done_pulse;
    logic          err_pulse;

    uart_mem_cmd_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(RDL), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .word_count(word_count), .busy(busy),
        .done_pulse(done_pulse), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory environment: RDL-stage read pipeline, junk when not reading.
    logic [DW-1:0] tb_mem  [2**AW];
    logic [DW-1:0] rd_pipe [RDL];
    always @(posedge clk) begin
        if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? tb_mem[mem_addr] : DW'($urandom);
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RDL-1];

    // UART environment: busy from the cycle after tx_start for 1..6 cycles.
    int busy_left;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy   <= 1'b0;
            busy_left <= 0;
        end else if (tx_start) begin
            tx_busy   <= 1'b1;
            busy_left <= int'($urandom_range(1, 6));
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left <= 0;
            tx_busy   <= 1'b0;
        end
    end

    // Monitors, sampled mid-cycle.
    u8_t    cap_tx[$];
    int     cap_wa[$];
    longint cap_wd[$];
    int     done_cnt, err_cnt;
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                cap_tx.push_back(tx_data);
                chk("tx_start_while_busy", longint'(tx_busy), 0);
                chk("mem_en_with_tx", longint'(mem_en), 0);
            end
            if (mem_we) chk("we_without_en", longint'(mem_en), 1);
            if (mem_en && mem_we) begin
                cap_wa.push_back(int'(mem_addr));
                cap_wd.push_back(longint'(mem_wdata));
            end
            if (done_pulse) begin
                done_cnt++;
                chk("done_with_D", longint'({tx_start, tx_data}), 'h144);
            end
            if (err_pulse) begin
                err_cnt++;
                chk("err_with_E", longint'({tx_start, tx_data}), 'h145);
            end
        end
    end

    // Reference: effect of one session on memory, word count and tx stream.
    longint exp_mem [DEP];
    int     exp_wc;

    task automatic model(input u8_t s[$], output u8_t et[$], output int wa[$],
                         output longint wd[$], output bit is_err);
        int     i = 0;
        longint acc = 0;
        bit     seen = 0;
        bit     fin = 0;
        u8_t    c;
        et = {}; wa = {}; wd = {}; is_err = 0;
        while (i < s.size() && s[i] != 8'h40) i++;
        i++;
        c = (i < s.size()) ? s[i] : 8'h00;
        i++;
        if (c == 8'h77 && i < s.size() && s[i] == 8'h0A) begin
            i++;
            exp_wc = 0;
            while (!fin && i < s.size()) begin
                c = s[i]; i++;
                if (c >= 8'h30 && c <= 8'h39) begin
                    acc = acc * 10 + longint'(c - 8'h30);
                    if (acc > MAXV) begin is_err = 1; fin = 1; end
                    else seen = 1;
                end else if (c == 8'h0A || c == 8'h24) begin
                    if (seen) begin
                        if (exp_wc == DEP) begin is_err = 1; fin = 1; end
                        else begin
                            exp_mem[exp_wc] = acc;
                            wa.push_back(exp_wc);
                            wd.push_back(acc);
                            exp_wc++;
                            acc = 0; seen = 0;
                        end
                    end
                    if (!is_err && c == 8'h24) fin = 1;
                end else begin
                    is_err = 1; fin = 1;
                end
            end
        end else if (c == 8'h72 && i < s.size() && s[i] == 8'h0A) begin
            for (int a = 0; a < exp_wc; a++)
                for (int b = BY - 1; b >= 0; b--)
                    et.push_back(u8_t'(exp_mem[a] >> (8 * b)));
        end else begin
            is_err = 1;
        end
        et.push_back(is_err ? 8'h45 : 8'h44);
        et.push_back(8'h0A);
    endtask

    task automatic send_byte(input u8_t b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        rx_data  = u8_t'($urandom);
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        #1;
        while ((busy || tx_busy || tx_start) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle_timeout"}, longint'(n < 5000), 1);
    endtask

    task automatic run_session(input string tag, input string s);
        u8_t    q[$];
        u8_t    et[$];
        int     ewa[$];
        longint ewd[$];
        bit     is_err;
        for (int i = 0; i < s.len(); i++) q.push_back(u8_t'(s[i]));
        model(q, et, ewa, ewd, is_err);
        cap_tx.delete(); cap_wa.delete(); cap_wd.delete();
        done_cnt = 0; err_cnt = 0;
        foreach (q[i]) send_byte(q[i]);
        wait_idle(tag);
        chk({tag, "_tx_len"}, cap_tx.size(), et.size());
        for (int i = 0; i < et.size() && i < cap_tx.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i), longint'(cap_tx[i]), longint'(et[i]));
        chk({tag, "_wr_len"}, cap_wa.size(), ewa.size());
        for (int i = 0; i < ewa.size() && i < cap_wa.size(); i++) begin
            chk($sformatf("%s_wa%0d", tag, i), cap_wa[i], ewa[i]);
            chk($sformatf("%s_wd%0d", tag, i), cap_wd[i], ewd[i]);
        end
        chk({tag, "_word_count"}, longint'(word_count), exp_wc);
        chk({tag, "_done_cnt"}, done_cnt, is_err ? 0 : 1);
        chk({tag, "_err_cnt"}, err_cnt, is_err ? 1 : 0);
        chk({tag, "_busy_end"}, longint'(busy), 0);
    endtask

    function automatic string rand_write();
        string s = "@w\n";
        int    n = int'($urandom_range(0, 7));
        longint v;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) s = {s, "\n"};
            if ($urandom_range(0, 11) == 0) v = MAXV + 1 + longint'($urandom_range(0, 999));
            else v = longint'($urandom_range(0, 65535));
            s = {s, $sformatf("%0d", v)};
            if (k < n - 1 || $urandom_range(0, 1) == 1) s = {s, "\n"};
        end
        if ($urandom_range(0, 9) == 0) s = {s, "x"};
        else s = {s, "$"};
        return s;
    endfunction

    initial begin
        int n0;
        int n;
        rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; exp_wc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_start", longint'(tx_start), 0);
        chk("rst_tx_data", longint'(tx_data), 0);
        chk("rst_mem_en", longint'(mem_en), 0);
        chk("rst_mem_we", longint'(mem_we), 0);
        chk("rst_mem_addr", longint'(mem_addr), 0);
        chk("rst_mem_wdata", longint'(mem_wdata), 0);
        chk("rst_word_count", longint'(word_count), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_pulses", longint'({done_pulse, err_pulse}), 0);
        rst = 1'b0;

        run_session("wr_basic", "ab\n9@w\n12\n255\n$");
        run_session("rd_basic", "@r\n");
        run_session("overflow", "@w\n65536\n");
        run_session("rd_empty", "@r\n");
        run_session("wr_4660", "@w\n4660$");
        run_session("rd_4660", "@r\n");
        run_session("full", "@w\n1\n2\n3\n4\n5\n6\n7\n");
        run_session("rd_full", "@r\n");
        run_session("bad_cmd", "@x");
        run_session("bad_whdr", "@wz");
        run_session("bad_rhdr", "@r5");
        run_session("bad_data", "@w\n12a");
        run_session("rd_after_err", "@r\n");
        run_session("blank_lines", "@w\n\n\n5\n\n$");
        run_session("rd_blank", "@r\n");
        run_session("wr_max", "@w\n65535\n0$");
        run_session("rd_max", "@r\n");
        run_session("wr_empty", "@w\n$");
        run_session("rd_none", "@r\n");

        for (int r = 0; r < 20; r++) begin
            run_session($sformatf("rnd_wr%0d", r), rand_write());
            run_session($sformatf("rnd_rd%0d", r), "@r\n");
        end

        // Reset in the middle of a read burst.
        run_session("pre_reset_wr", "@w\n100\n200\n300\n400\n500\n600$");
        cap_tx.delete();
        send_byte(8'h40); send_byte(8'h72); send_byte(8'h0A);
        n = 0;
        while (cap_tx.size() < 3 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("mid_read_reached", longint'(cap_tx.size() >= 3), 1);
        #2;
        rst = 1'b1;
        n0 = cap_tx.size();
        #1;
        chk("async_rst_tx_start", longint'(tx_start), 0);
        chk("async_rst_busy", longint'(busy), 0);
        chk("async_rst_mem_en", longint'(mem_en), 0);
        chk("async_rst_word_count", longint'(word_count), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("in_rst_tx_start", longint'(tx_start), 0);
        rst = 1'b0;
        exp_wc = 0;
        repeat (20) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", longint'({tx_start, mem_en, busy}), 0);
        end
        chk("post_rst_no_tx", cap_tx.size(), n0);
        run_session("rd_after_reset", "@r\n");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
